alu_seq: RTL

Registered, parametrised-width ALU with a start/done handshake, a flags register and a byte-paged LED readout. It replaces the purely combinational switch-driven ALU on the lab board. Operands and opcode are captured on `start`, and the result and flags are held until the next operation. It sits between the operand/switch front end and the 8-bit LED bank.

---
 rtl/alu_seq.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
//
// Registered ALU with a start/done handshake, a flags register and a
// byte-paged LED readout. Operands and opcode are taken on an accepted
// start; result and flags are held until the next operation completes.
//
// Parameters:
//   W   datapath width, multiple of 8, minimum 8
//   SW  width of led_sel; 2**SW must exceed W/8 so the flags page exists
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   start    operation request, sampled only while idle
//   op       000 AND, 001 OR, 010 XOR, 011 XNOR, 100 ADD, 101 SUB,
//            110 SLTU, 111 SLL
//   a        operand A (shift amount for SLL)
//   b        operand B
//   busy     iterative shift in progress
//   done     one-cycle pulse: result and flags just updated
//   result   registered result
//   zf/cf/of registered zero, carry/borrow and signed-overflow flags
//   led_sel  LED page select (result byte, or flags page beyond W/8)
//   led      LED drive
//
// Configuration macro:
//   ALU_SEQ_BARREL_EN  when defined, SLL completes in one cycle through a
//                      barrel shifter and the SHIFT state is never entered.
//                      Undefined (default): SLL shifts one bit per cycle.
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int W  = 32,
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result,
    output logic          zf,
    output logic          cf,
    output logic          of,
    input  logic [SW-1:0] led_sel,
    output logic [7:0]    led
);

    // Counter must be able to hold the value W itself (full-width shift).
    localparam int           CW    = $clog2(W + 1);
    localparam int           NB    = W / 8;
    localparam logic [W-1:0] W_VEC = W'(W);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_XNOR = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;
    localparam logic [2:0] OP_SLL  = 3'b111;

`ifdef ALU_SEQ_BARREL_EN
    localparam bit ITER_SHIFT = 1'b0;
`else
    localparam bit ITER_SHIFT = 1'b1;
`endif

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [W-1:0]    sh_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    res_q;
    logic            zf_q;
    logic            cf_q;
    logic            of_q;
    logic            done_q;

    logic [W:0]      sum_w;
    logic [W:0]      dif_w;
    logic [W-1:0]    alu_f;
    logic            alu_c;
    logic            alu_o;

    // Shift amount clamped to W: any amount >= W shifts everything out.
    function automatic logic [CW-1:0] sat_shamt(input logic [W-1:0] amt);
        if (amt >= W_VEC)
            return W_VEC[CW-1:0];
        else
            return amt[CW-1:0];
    endfunction

    // Addition overflows when both operands share a sign the result lacks.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                     input logic f_msb);
        return (a_msb == b_msb) && (f_msb != a_msb);
    endfunction

    // Subtraction overflows when operand signs differ and the result takes
    // the sign of the subtrahend.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                     input logic f_msb);
        return (a_msb != b_msb) && (f_msb != a_msb);
    endfunction

    // Single-cycle operations, evaluated straight from the input operands.
    always_comb begin
        sum_w = {1'b0, a} + {1'b0, b};
        dif_w = {1'b0, a} - {1'b0, b};
        alu_f = '0;
        alu_c = 1'b0;
        alu_o = 1'b0;
        case (op)
            OP_AND:  alu_f = a & b;
            OP_OR:   alu_f = a | b;
            OP_XOR:  alu_f = a ^ b;
            OP_XNOR: alu_f = ~(a ^ b);
            OP_ADD: begin
                alu_f = sum_w[W-1:0];
                alu_c = sum_w[W];
                alu_o = add_ovf(a[W-1], b[W-1], sum_w[W-1]);
            end
            OP_SUB: begin
                // Extra top bit of the W+1 difference is the borrow.
                alu_f = dif_w[W-1:0];
                alu_c = dif_w[W];
                alu_o = sub_ovf(a[W-1], b[W-1], dif_w[W-1]);
            end
            OP_SLTU: alu_f = {{(W-1){1'b0}}, (a < b)};
            OP_SLL: begin
`ifdef ALU_SEQ_BARREL_EN
                alu_f = b << sat_shamt(a);
`else
                alu_f = '0;
`endif
            end
            default: alu_f = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && ITER_SHIFT && (op == OP_SLL))
                    state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt_q == '0)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == S_SHIFT);
    end

    // Result, flags, shifter and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
            zf_q   <= 1'b1;
            cf_q   <= 1'b0;
            of_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (ITER_SHIFT && (op == OP_SLL)) begin
                            sh_q  <= b;
                            cnt_q <= sat_shamt(a);
                        end else begin
                            res_q  <= alu_f;
                            zf_q   <= (alu_f == '0);
                            cf_q   <= alu_c;
                            of_q   <= alu_o;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    // One extra cycle at count zero commits the result, so a
                    // shift by n keeps busy high for n+1 cycles.
                    if (cnt_q != '0) begin
                        sh_q  <= sh_q << 1;
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        res_q  <= sh_q;
                        zf_q   <= (sh_q == '0);
                        cf_q   <= 1'b0;
                        of_q   <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // LED page: result bytes first, flags page for any higher selection.
    always_comb begin
        led = {zf_q, 5'b00000, cf_q, of_q};
        for (int i = 0; i < NB; i++) begin
            if (led_sel == SW'(i))
                led = res_q[8*i +: 8];
        end
    end

    assign done   = done_q;
    assign result = res_q;
    assign zf     = zf_q;
    assign cf     = cf_q;
    assign of     = of_q;

endmodule
